seq_div16x8: RTL and testbench

- Sequential restoring divider; the inverse of the team's 8x8 Vedic multiplier.
- Divides a 2N-bit dividend by an N-bit divisor and returns an N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock, using a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath: product in, original operand back out.

---
 rtl/seq_div16x8.sv | 93 +++++++++
 tb/tb_seq_div16x8.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seq_div16x8.sv
// seq_div16x8: sequential restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock
module seq_div16x8 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;
    logic [N-1:0]  d, r, s, q_sh, q_next, r_next;
    logic [N:0]    t, diff;
    logic [CW-1:0] cnt;
    logic          err, accept, last;

    assign err    = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CW'(N-1));
    assign t      = {r, s[N-1]};
    // Top bit of the difference is the borrow: set exactly when T < divisor
    assign diff   = t - {1'b0, d};
    assign r_next = diff[N] ? t[N-1:0] : diff[N-1:0];
    assign q_next = {q_sh[N-2:0], ~diff[N]};

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = start ? (err ? DONE : RUN) : IDLE;
        else if (state == RUN)
            state_next = last ? DONE : RUN;
        else
            state_next = IDLE;
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d           <= '0;
            r           <= '0;
            s           <= '0;
            q_sh        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            d           <= divisor;
            r           <= dividend[2*N-1:N];
            s           <= dividend[N-1:0];
            q_sh        <= '0;
            cnt         <= '0;
            div_by_zero <= (divisor == '0);
            overflow    <= (divisor != '0) && (dividend[2*N-1:N] >= divisor);
            if (err) begin
                quotient  <= '1;
                remainder <= '0;
            end
        end else if (state == RUN) begin
            r    <= r_next;
            s    <= {s[N-2:0], 1'b0};
            q_sh <= q_next;
            cnt  <= cnt + 1'b1;
            // Visible results change only on the final iteration
            if (last) begin
                quotient  <= q_next;
                remainder <= r_next;
            end
        end
    end
endmodule

// File: tb/tb_seq_div16x8.sv
// tb_seq_div16x8: directed and random checks of seq_div16x8 against an arithmetic reference model
module tb_seq_div16x8;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, div_by_zero, overflow;
    logic [15:0] dividend;
    logic [7:0]  divisor, quotient, remainder;
    logic [7:0]  held_q, held_r;
    logic        held_z, held_o;
    int          tests = 0;
    int          fails = 0;

    seq_div16x8 dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_q"}, 32'(quotient), 32'(held_q));
        chk({tag, "_r"}, 32'(remainder), 32'(held_r));
        chk({tag, "_z"}, 32'(div_by_zero), 32'(held_z));
        chk({tag, "_o"}, 32'(overflow), 32'(held_o));
    endtask

    // Entered and left at a negedge of an IDLE cycle; the start is driven immediately.
    task automatic do_op(input logic [15:0] dv, input logic [7:0] ds, input bit mid_start);
        logic [7:0] eq, er;
        logic       ez, eo;
        int         lat;
        bit         held_ok;
        ez = (ds == 0);
        eo = !ez && (dv[15:8] >= ds);
        eq = (ez || eo) ? 8'hFF : 8'(dv / ds);
        er = (ez || eo) ? 8'h00 : 8'(dv % ds);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        dividend = dv;
        divisor  = ds;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        held_ok = 1'b1;
        while (!done && lat < 20) begin
            if (quotient !== held_q || remainder !== held_r || !busy) held_ok = 1'b0;
            start = mid_start && (lat == 3);
            if (start) begin
                dividend = 16'h0064;
                divisor  = 8'h03;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("run_stable", 32'(held_ok), 1);
        chk("latency", lat, (ez || eo) ? 1 : 9);
        chk("done_busy", 32'(busy), 1);
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(ez));
        chk("overflow", 32'(overflow), 32'(eo));
        if (!ez && !eo) begin
            chk("identity", 32'(quotient) * 32'(ds) + 32'(remainder), 32'(dv));
            chk("rem_lt_div", 32'(remainder < ds), 1);
        end
        held_q = eq;
        held_r = er;
        held_z = ez;
        held_o = eo;
        @(negedge clk);
        chk_held("hold");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        held_q   = '0;
        held_r   = '0;
        held_z   = 1'b0;
        held_o   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_held("reset");
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        do_op(16'h03E8, 8'h07, 1'b0);
        do_op(16'hFEFF, 8'hFF, 1'b0);
        do_op(16'h0000, 8'h05, 1'b0);
        do_op(16'h1234, 8'h00, 1'b0);
        do_op(16'hFFFF, 8'hFF, 1'b0);
        do_op(16'h03E8, 8'h07, 1'b1);
        do_op(16'h00FF, 8'h01, 1'b0);

        dividend = 16'h03E8;
        divisor  = 8'h07;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        held_q = '0;
        held_r = '0;
        held_z = 1'b0;
        held_o = 1'b0;
        chk_held("abort");
        chk("abort_busy", 32'(busy), 0);
        begin
            bit saw_done = 1'b0;
            repeat (12) begin
                if (done || busy) saw_done = 1'b1;
                @(negedge clk);
            end
            chk("abort_no_done", 32'(saw_done), 0);
        end
        do_op(16'h0064, 8'h0A, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] ds, hi, lo;
            ds = 8'($urandom_range(1, 255));
            hi = 8'($urandom_range(0, 32'(ds) - 1));
            lo = 8'($urandom);
            do_op({hi, lo}, ds, 1'b0);
        end
        for (int i = 0; i < 300; i++)
            do_op(16'($urandom), 8'($urandom_range(0, 15)), i % 7 == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
